// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline control logic.
//   pipe_state_e : hazard controller FSM states
//   FWD_*        : EX operand forwarding selects
//   REG_X0       : hard-wired zero register index
package riscv_pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   master : datapath side (drives stage register indices and memory status,
//            receives enables, flushes, forwarding selects and counters)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1, id_rs2;
  logic             id_uses_rs1, id_uses_rs2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_mem_read, ex_branch_taken;
  logic [4:0]       mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  logic             dmem_req, dmem_ready;
  logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic             if_id_flush, id_ex_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_branch_taken, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
           dmem_req, dmem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, stall_cycles, flush_count, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_branch_taken, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
           dmem_req, dmem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           fwd_a, fwd_b, stall_cycles, flush_count, mem_timeout
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : increment request for this cycle
//   count : current value, holds at all-ones
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard bundle (slave) - stage register indices, memory status in;
//              register write enables, bubble flushes, forwarding selects,
//              stall/flush counters and sticky memory-timeout flag out
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  // One spare bit so the saturating wait counter can pass MEM_TIMEOUT.
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1) + 1;

  pipe_state_e      r_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic             r_mem_timeout;

  logic [WaitW-1:0] w_wait_next;
  logic             w_freeze, w_load_use, w_flush_inc;
  logic             w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we, w_mem_wb_we;
  logic             w_if_id_flush, w_id_ex_flush;

  // Once in MEM_WAIT the access is outstanding even if dmem_req drops.
  assign w_freeze = ~hz.dmem_ready & (hz.dmem_req | (r_state == MEM_WAIT));

  assign w_load_use = hz.ex_mem_read && (hz.ex_rd != REG_X0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  assign w_wait_next = (r_state == RUN) ? WaitW'(1) :
                       (&r_wait_cnt)    ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_freeze) begin
      r_state    <= MEM_WAIT;
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == WaitW'(MEM_TIMEOUT)) begin
        r_mem_timeout <= 1'b1;
      end
    end else begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end
  end

  // Priority: reset, memory freeze, taken branch, load-use, normal.
  always_comb begin
    w_pc_we       = 1'b1;
    w_if_id_we    = 1'b1;
    w_id_ex_we    = 1'b1;
    w_ex_mem_we   = 1'b1;
    w_mem_wb_we   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_flush_inc   = 1'b0;
    if (rst || w_freeze) begin
      w_pc_we     = 1'b0;
      w_if_id_we  = 1'b0;
      w_id_ex_we  = 1'b0;
      w_ex_mem_we = 1'b0;
      w_mem_wb_we = 1'b0;
    end else if (hz.ex_branch_taken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_flush_inc   = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and IF/ID, bubble into EX; the load itself moves on.
      w_pc_we       = 1'b0;
      w_if_id_we    = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    hz.fwd_a = FWD_REG;
    if (hz.mem_reg_write && (hz.mem_rd != REG_X0) && (hz.mem_rd == hz.ex_rs1)) begin
      hz.fwd_a = FWD_MEM;
    end else if (hz.wb_reg_write && (hz.wb_rd != REG_X0) && (hz.wb_rd == hz.ex_rs1)) begin
      hz.fwd_a = FWD_WB;
    end
  end

  always_comb begin
    hz.fwd_b = FWD_REG;
    if (hz.mem_reg_write && (hz.mem_rd != REG_X0) && (hz.mem_rd == hz.ex_rs2)) begin
      hz.fwd_b = FWD_MEM;
    end else if (hz.wb_reg_write && (hz.wb_rd != REG_X0) && (hz.wb_rd == hz.ex_rs2)) begin
      hz.fwd_b = FWD_WB;
    end
  end

  assign hz.pc_we       = w_pc_we;
  assign hz.if_id_we    = w_if_id_we;
  assign hz.id_ex_we    = w_id_ex_we;
  assign hz.ex_mem_we   = w_ex_mem_we;
  assign hz.mem_wb_we   = w_mem_wb_we;
  assign hz.if_id_flush = w_if_id_flush;
  assign hz.id_ex_flush = w_id_ex_flush;
  assign hz.mem_timeout = r_mem_timeout;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~w_pc_we),
    .count (hz.stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (hz.flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  import riscv_pipe_pkg::*;

  localparam int unsigned CntW = 4;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(CntW)) hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       uses1, uses2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_read, br;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_rw, wb_rw;
    logic [4:0] exp_we;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] exp_fl;   // {if_id, id_ex}
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] we_vec();
    return {hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.mem_wb_we};
  endfunction

  function automatic logic [1:0] fl_vec();
    return {hz.if_id_flush, hz.id_ex_flush};
  endfunction

  task automatic check_ctl(input string name, input logic [4:0] we, input logic [1:0] fl);
    check({name, "_we"}, 32'(we_vec()), 32'(we));
    check({name, "_flush"}, 32'(fl_vec()), 32'(fl));
  endtask

  task automatic idle_inputs();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd0; hz.ex_rd = 5'd0;
    hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.mem_reg_write = 1'b0; hz.wb_reg_write = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  task automatic load_use_inputs();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ctl({name, "_in_rst"}, 5'b00000, 2'b00);
    check({name, "_stall0"}, 32'(hz.stall_cycles), 32'd0);
    check({name, "_flush0"}, 32'(hz.flush_count), 32'd0);
    check({name, "_tmo0"}, 32'(hz.mem_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // id_rs1 id_rs2 u1 u2 ex_rs1 ex_rs2 ex_rd mrd br mem_rd wb_rd mrw wrw | we fl fa fb
    vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd8, 1'b0, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b00111, 2'b01, 2'b00, 2'b00};
    vecs[2]  = '{5'd1, 5'd6, 1'b1, 1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b00111, 2'b01, 2'b00, 2'b00};
    vecs[3]  = '{5'd0, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{5'd5, 5'd2, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 5'd10, 5'd11, 1'b1, 1'b1,
                 5'b11111, 2'b11, 2'b00, 2'b00};
    vecs[7]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 5'd3, 5'd8, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b10, 2'b00};
    vecs[8]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 5'd3, 5'd8, 1'b0, 1'b0, 5'd7, 5'd7, 1'b0, 1'b1,
                 5'b11111, 2'b00, 2'b01, 2'b00};
    vecs[9]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 5'd3, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 5'd9, 5'd8, 1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b10};
    vecs[11] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 5'd12, 5'd8, 1'b0, 1'b0, 5'd12, 5'd12, 1'b0, 1'b1,
                 5'b11111, 2'b00, 2'b00, 2'b01};
    vecs[12] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 5'd4, 5'd8, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0,
                 5'b11111, 2'b00, 2'b10, 2'b00};

    rst = 1'b1;
    idle_inputs();
    #1;
    check_ctl("reset", 5'b00000, 2'b00);
    check("reset_stall", 32'(hz.stall_cycles), 32'd0);
    check("reset_flushcnt", 32'(hz.flush_count), 32'd0);
    check("reset_tmo", 32'(hz.mem_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational vectors in RUN state.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      hz.id_rs1 = vecs[i].id_rs1; hz.id_rs2 = vecs[i].id_rs2;
      hz.id_uses_rs1 = vecs[i].uses1; hz.id_uses_rs2 = vecs[i].uses2;
      hz.ex_rs1 = vecs[i].ex_rs1; hz.ex_rs2 = vecs[i].ex_rs2; hz.ex_rd = vecs[i].ex_rd;
      hz.ex_mem_read = vecs[i].mem_read; hz.ex_branch_taken = vecs[i].br;
      hz.mem_rd = vecs[i].mem_rd; hz.wb_rd = vecs[i].wb_rd;
      hz.mem_reg_write = vecs[i].mem_rw; hz.wb_reg_write = vecs[i].wb_rw;
      hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
      #1;
      check_ctl($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_fl);
      check($sformatf("vec%0d_fwd_a", i), 32'(hz.fwd_a), 32'(vecs[i].exp_fa));
      check($sformatf("vec%0d_fwd_b", i), 32'(hz.fwd_b), 32'(vecs[i].exp_fb));
    end
    idle_inputs();

    // Load-use: one bubble, then flowing again.
    do_reset("lu");
    load_use_inputs();
    #1;
    check_ctl("lu_bubble", 5'b00111, 2'b01);
    @(negedge clk);
    idle_inputs();
    #1;
    check_ctl("lu_after", 5'b11111, 2'b00);
    check("lu_stall_cnt", 32'(hz.stall_cycles), 32'd1);

    // Loads that must not stall.
    do_reset("nolu");
    load_use_inputs();
    hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
    @(negedge clk);
    load_use_inputs();
    hz.id_uses_rs1 = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    check("nolu_stall_cnt", 32'(hz.stall_cycles), 32'd0);

    // Branch overrides load-use.
    do_reset("br");
    load_use_inputs();
    hz.ex_branch_taken = 1'b1;
    #1;
    check_ctl("br_lu", 5'b11111, 2'b11);
    @(negedge clk);
    idle_inputs();
    #1;
    check("br_flush_cnt", 32'(hz.flush_count), 32'd1);
    check("br_stall_cnt", 32'(hz.stall_cycles), 32'd0);

    // 3-cycle memory wait; ready cycle also carries a taken branch.
    do_reset("mw");
    hz.dmem_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      check_ctl($sformatf("mw_frozen%0d", k), 5'b00000, 2'b00);
    end
    @(negedge clk);
    hz.dmem_ready = 1'b1;
    hz.ex_branch_taken = 1'b1;
    #1;
    check_ctl("mw_ready_br", 5'b11111, 2'b11);
    @(negedge clk);
    idle_inputs();
    #1;
    check_ctl("mw_run", 5'b11111, 2'b00);
    check("mw_stall_cnt", 32'(hz.stall_cycles), 32'd3);
    check("mw_flush_cnt", 32'(hz.flush_count), 32'd1);
    check("mw_no_tmo", 32'(hz.mem_timeout), 32'd0);

    // Timeout after the 4th wait cycle, sticky past ready.
    do_reset("tmo");
    hz.dmem_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("tmo_after%0d", k), 32'(hz.mem_timeout), 32'(k >= 4));
      check_ctl($sformatf("tmo_frozen%0d", k), 5'b00000, 2'b00);
    end
    @(negedge clk);
    hz.dmem_ready = 1'b1;
    #1;
    check_ctl("tmo_ready", 5'b11111, 2'b00);
    @(negedge clk);
    idle_inputs();
    #1;
    check("tmo_sticky", 32'(hz.mem_timeout), 32'd1);
    check("tmo_stall_cnt", 32'(hz.stall_cycles), 32'd6);

    // Long wait saturates stall counter; branches saturate flush counter.
    hz.dmem_req = 1'b1;
    repeat (12) @(negedge clk);
    hz.dmem_req = 1'b0;
    hz.dmem_ready = 1'b1;
    hz.ex_branch_taken = 1'b1;
    repeat (17) @(negedge clk);
    idle_inputs();
    #1;
    check("sat_stall", 32'(hz.stall_cycles), 32'd15);
    check("sat_flush", 32'(hz.flush_count), 32'd15);

    // Reset mid-wait clears everything and returns to RUN at once.
    hz.dmem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ctl("rstwait_in_rst", 5'b00000, 2'b00);
    check("rstwait_tmo", 32'(hz.mem_timeout), 32'd0);
    check("rstwait_stall", 32'(hz.stall_cycles), 32'd0);
    check("rstwait_flush", 32'(hz.flush_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hz.dmem_req = 1'b0;
    #1;
    check_ctl("rstwait_run", 5'b11111, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
